rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Four-input round-robin arbiter that drains the four ingress FIFOs (fifo0..fifo3) one word per cycle and presents a single registered stream (data_inter, destino, valid_out) to the destination demux feeding egress FIFOs fifo4..fifo7. Each word carries its destination in bits [9:8]. A source is served only when its head word's destination FIFO is not almost-full, so no word is ever pushed into a full egress FIFO.

## Interface
Parameters:
- DATA_W, 10, word width.
- DEST_LSB, 8, LSB of the 2-bit destination field inside a word (destino = word[DEST_LSB+1:DEST_LSB]).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in0..data_in3  input  DATA_W each  head word of ingress FIFO 0..3 (first-word-fall-through: valid whenever matching empty is 0).
- empty0..empty3  input  1 each  ingress FIFO empty flags.
- almost_full4..almost_full7  input  1 each  egress FIFO almost-full flags, indexed by destino 0..3.
- pop0..pop3  output  1 each  consume head word of ingress FIFO 0..3 (combinational, one-hot or zero).
- data_inter  output  DATA_W  registered forwarded word.
- destino  output  2  registered destination of data_inter.
- valid_out  output  1  data_inter/destino valid this cycle (push strobe for the selected egress FIFO).
- grant  output  2  registered index of the source that supplied data_inter.
- word_count  output  8  registered count of forwarded words, wraps 255 -> 0.
- idle  output  1  registered; 1 when all ingress FIFOs empty and valid_out is 0.

## Operation
- Eligibility of source i: empty_i == 0 and almost_full[4 + data_in_i[9:8]] == 0.
- Priority pointer ptr (2 bits, reset 0). Search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first eligible source wins.
- Winner w: pop_w = 1 in the same cycle; at the rising edge data_inter <= data_in_w, destino <= data_in_w[9:8], grant <= w, valid_out <= 1, word_count += 1, ptr <= w+1 mod 4.
- No eligible source: all pops 0, valid_out <= 0, data_inter/destino/grant hold, ptr holds, word_count holds.
- Ineligible sources (blocked by almost-full) are skipped without losing their turn order; ptr moves only on a grant.
- State machine (2 states, reset IDLE):
  - IDLE: valid_out 0. Any eligible source -> ACTIVE (grant issued on that edge).
  - ACTIVE: a word was forwarded last cycle. Eligible source -> stay ACTIVE; none -> IDLE.
  - valid_out == (state == ACTIVE).
- idle <= (all empty_i == 1) and no grant this cycle.
- At most one pop per cycle; pop never asserted while reset_L == 0.

## Timing
- Reset (reset_L low, asynchronous): data_inter 0, destino 0, grant 0, valid_out 0, word_count 0, idle 1, ptr 0, state IDLE; pops forced 0 immediately. Reset mid-transfer drops the in-flight word on the output; the popped ingress word is not restored.
- Latency: pop in cycle t -> word on data_inter with valid_out = 1 in cycle t+1, for exactly one cycle per grant.
- Throughput: one word per cycle sustained; back-to-back grants rotate across all non-blocked sources.
- Egress almost-full must assert with at least 1 word of headroom (one word can be in flight after the flag rises).
- almost_full and empty are sampled combinationally in the grant cycle; a flag changing mid-cycle affects only that cycle's decision.
- word_count wraps 8'hFF -> 8'h00 with no side effect.

## Test plan
- Reset: hold reset_L low with all FIFOs non-empty -> pops 0, valid_out 0, word_count 0, idle 1; release -> first grant to source 0 on the next edge.
- All four sources with 3 words each, no almost-full -> grant sequence 0,1,2,3,0,1,2,3,0,1,2,3, valid_out high 12 consecutive cycles, word_count 12, then idle 1.
- Sources 0 and 2 head words destined to 1 with almost_full5 = 1, sources 1 and 3 to 0 -> only sources 1 and 3 granted, alternating; release almost_full5 -> ptr order resumes with 0 or 2 as next in rotation.
- Single source 3 with 5 words, destino 2 (word 10'h2AB) -> data_inter 10'h2AB, destino 2, grant 3 each cycle for 5 cycles, pop3 high 5 cycles.
- 256 forwarded words -> word_count returns to 0 and forwarding continues uninterrupted.
- Assert reset_L low in a cycle where pop1 is high -> pop1 drops immediately, outputs clear; after release arbitration restarts at ptr 0.

Source files
------------

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Four-input round-robin arbiter. Drains ingress FIFOs 0..3 one
//             word per cycle into a single registered stream for the egress
//             demux (fifo4..fifo7). A source is only served when the egress
//             FIFO named by its head word's destination field is not
//             almost-full.
//  Ports    : clk, reset_L (async, active-low)
//             data_in0..3 / empty0..3 : FWFT heads and empty flags of ingress
//             almost_full4..7         : egress almost-full, indexed by destino
//             pop0..3                 : combinational one-hot pop strobes
//             data_inter, destino     : registered forwarded word and dest
//             valid_out               : push strobe for the egress FIFO
//             grant                   : registered index of the served source
//             word_count              : registered forwarded-word count (wraps)
//             idle                    : registered all-empty, nothing in flight
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int DATA_W   = 10,
    parameter int DEST_LSB = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              empty0,
    input  logic              empty1,
    input  logic              empty2,
    input  logic              empty3,
    input  logic              almost_full4,
    input  logic              almost_full5,
    input  logic              almost_full6,
    input  logic              almost_full7,
    output logic              pop0,
    output logic              pop1,
    output logic              pop2,
    output logic              pop3,
    output logic [DATA_W-1:0] data_inter,
    output logic [1:0]        destino,
    output logic              valid_out,
    output logic [1:0]        grant,
    output logic [7:0]        word_count,
    output logic              idle
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

    logic [DATA_W-1:0] w_data [4];
    logic [1:0]        w_dest [4];
    logic [3:0]        w_empty;
    logic [3:0]        w_af;
    logic [3:0]        w_elig;
    logic [3:0]        w_pop;
    logic              w_any;
    logic [1:0]        w_win;
    logic [1:0]        w_idx;
    logic [0:0]        w_state_nxt;

    logic [0:0]        r_state;
    logic [1:0]        r_ptr;

    assign w_data[0] = data_in0;
    assign w_data[1] = data_in1;
    assign w_data[2] = data_in2;
    assign w_data[3] = data_in3;
    assign w_empty   = {empty3, empty2, empty1, empty0};
    assign w_af      = {almost_full7, almost_full6, almost_full5, almost_full4};

    // A source is eligible only if it has a word and that word's egress
    // FIFO can still take it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_elig
            assign w_dest[gi] = w_data[gi][DEST_LSB+1:DEST_LSB];
            assign w_elig[gi] = ~w_empty[gi] & ~w_af[w_dest[gi]];
        end
    endgenerate

    // First eligible source in rotation order starting at the pointer.
    // Blocked sources are skipped without disturbing the pointer.
    always_comb begin
        w_any = 1'b0;
        w_win = 2'd0;
        w_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_any && w_elig[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Pops are gated by reset_L so they drop the moment reset asserts,
    // without waiting for a clock edge.
    always_comb begin
        w_pop = 4'b0000;
        if (reset_L && w_any) begin
            w_pop[w_win] = 1'b1;
        end
    end

    assign pop0 = w_pop[0];
    assign pop1 = w_pop[1];
    assign pop2 = w_pop[2];
    assign pop3 = w_pop[3];

    // Next state: ACTIVE whenever a word is granted this cycle.
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        if (w_any) begin
            w_state_nxt = c_ST_ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign valid_out = (r_state == c_ST_ACTIVE);

    // Datapath registers: output word, destination, grant index, pointer
    // and counter all advance only on a grant.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_ptr      <= 2'd0;
            data_inter <= '0;
            destino    <= 2'd0;
            grant      <= 2'd0;
            word_count <= 8'd0;
            idle       <= 1'b1;
        end else begin
            idle <= (&w_empty) & ~w_any;
            if (w_any) begin
                r_ptr      <= w_win + 2'd1;
                data_inter <= w_data[w_win];
                destino    <= w_dest[w_win];
                grant      <= w_win;
                word_count <= word_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter
//  Purpose  : Self-checking bench for rr_arbiter. Ingress FIFOs are modelled
//             as queues; a rotation-order reference predicts pops and the
//             registered output stream each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [9:0] din [4];
    logic [3:0] emp;
    logic [3:0] af;
    logic       pop0, pop1, pop2, pop3;
    logic [9:0] data_inter;
    logic [1:0] destino;
    logic       valid_out;
    logic [1:0] grant;
    logic [7:0] word_count;
    logic       idle;

    always #5 clk = ~clk;

    rr_arbiter #(.DATA_W(10), .DEST_LSB(8)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .data_in0     (din[0]),
        .data_in1     (din[1]),
        .data_in2     (din[2]),
        .data_in3     (din[3]),
        .empty0       (emp[0]),
        .empty1       (emp[1]),
        .empty2       (emp[2]),
        .empty3       (emp[3]),
        .almost_full4 (af[0]),
        .almost_full5 (af[1]),
        .almost_full6 (af[2]),
        .almost_full7 (af[3]),
        .pop0         (pop0),
        .pop1         (pop1),
        .pop2         (pop2),
        .pop3         (pop3),
        .data_inter   (data_inter),
        .destino      (destino),
        .valid_out    (valid_out),
        .grant        (grant),
        .word_count   (word_count),
        .idle         (idle)
    );

    // Reference state
    logic [9:0] q [4][$];
    int         ptr;
    int         exp_data, exp_dest, exp_grant, exp_valid, exp_cnt, exp_idle;
    int         total_grants;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            emp[i] = (q[i].size() == 0);
            din[i] = (q[i].size() != 0) ? q[i][0] : 10'($urandom);
        end
    endtask

    function automatic int pick_winner();
        int w;
        logic [9:0] h;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            int s;
            s = (ptr + k) % 4;
            if (w < 0 && q[s].size() > 0) begin
                h = q[s][0];
                if (af[h[9:8]] == 1'b0) w = s;
            end
        end
        return w;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".data"},  32'(data_inter), 32'(exp_data));
        check({tag, ".dest"},  32'(destino),    32'(exp_dest));
        check({tag, ".grant"}, 32'(grant),      32'(exp_grant));
        check({tag, ".valid"}, 32'(valid_out),  32'(exp_valid));
        check({tag, ".count"}, 32'(word_count), 32'(exp_cnt));
        check({tag, ".idle"},  32'(idle),       32'(exp_idle));
    endtask

    // One cycle: entered just after a falling edge, leaves just after the
    // next falling edge.
    task automatic step(input string tag);
        int w;
        int all_empty;
        logic [9:0] word;
        drive_inputs();
        #1;
        w = pick_winner();
        all_empty = (q[0].size() == 0 && q[1].size() == 0 &&
                     q[2].size() == 0 && q[3].size() == 0);
        check({tag, ".pop"}, 32'({pop3, pop2, pop1, pop0}),
              (w >= 0) ? (32'd1 << w) : 32'd0);
        @(posedge clk);
        #1;
        if (w >= 0) begin
            word = q[w].pop_front();
            exp_data  = int'(word);
            exp_dest  = int'(word[9:8]);
            exp_grant = w;
            exp_valid = 1;
            exp_cnt   = (exp_cnt + 1) % 256;
            ptr       = (w + 1) % 4;
            total_grants++;
        end else begin
            exp_valid = 0;
        end
        exp_idle = all_empty;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic model_reset();
        ptr = 0; exp_data = 0; exp_dest = 0; exp_grant = 0;
        exp_valid = 0; exp_cnt = 0; exp_idle = 1;
    endtask

    function automatic logic [9:0] mkword(input int dest);
        logic [9:0] v;
        v = 10'($urandom);
        v[9:8] = 2'(dest);
        return v;
    endfunction

    initial begin
        total_grants = 0;
        af = 4'b0000;
        model_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) q[i].push_back(mkword($urandom_range(0, 3)));

        // Reset held with every source non-empty
        @(negedge clk);
        drive_inputs();
        #1;
        check("rst.pop", 32'({pop3, pop2, pop1, pop0}), 32'd0);
        @(posedge clk); #1;
        check_outputs("rst");
        @(negedge clk);
        reset_L = 1'b1;

        // Four sources, three words each: strict 0,1,2,3 rotation
        for (int n = 0; n < 12; n++) step("rot");
        check("rot.count12", 32'(word_count), 32'd12);
        step("rot.drain");
        check("rot.idle", 32'(idle), 32'd1);

        // Sources 0/2 blocked on egress 5; 1/3 alternate until released
        for (int j = 0; j < 2; j++) begin
            q[0].push_back(mkword(1)); q[2].push_back(mkword(1));
        end
        for (int j = 0; j < 3; j++) begin
            q[1].push_back(mkword(0)); q[3].push_back(mkword(0));
        end
        af = 4'b0010;
        for (int n = 0; n < 4; n++) step("blk");
        af = 4'b0000;
        for (int n = 0; n < 8; n++) step("unblk");

        // Single source 3, five copies of 10'h2AB
        for (int j = 0; j < 5; j++) q[3].push_back(10'h2AB);
        for (int n = 0; n < 6; n++) step("single");

        // Random traffic and back-pressure long enough to wrap the counter
        for (int n = 0; n < 2000 && total_grants < 320; n++) begin
            for (int i = 0; i < 4; i++)
                if (q[i].size() < 4 && $urandom_range(0, 1) == 1)
                    q[i].push_back(mkword($urandom_range(0, 3)));
            af = 4'($urandom) & 4'($urandom) & 4'($urandom);
            step("rand");
        end
        check("rand.enough", 32'(total_grants >= 320), 32'd1);
        af = 4'b0000;

        // Reset while pop1 is asserted
        for (int i = 0; i < 4; i++) q[i].delete();
        q[1].push_back(mkword(2));
        drive_inputs();
        #1;
        check("midrst.pop_before", 32'({pop3, pop2, pop1, pop0}), 32'b0010);
        reset_L = 1'b0;
        #1;
        model_reset();
        check("midrst.pop_after", 32'({pop3, pop2, pop1, pop0}), 32'd0);
        check_outputs("midrst");
        @(negedge clk);
        reset_L = 1'b1;
        q[0].push_back(mkword(3));
        step("postrst");
        check("postrst.grant0", 32'(grant), 32'd0);
        for (int n = 0; n < 3; n++) step("postrst.tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no end expected end");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
